// File: rtl/alarm_i2c_pkg.sv
// Shared types and constants for the alarm-to-I2C message queue.
package alarm_i2c_pkg;

    localparam logic [7:0] REG_SENSOR_BASE  = 8'h10;
    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h20;

    typedef struct packed {
        logic [7:0] regnum;
        logic [7:0] data;
    } msg_t;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        WAIT
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head and occupancy count.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/alarm_i2c_msg_queue.sv
// Turns armed sensor rising edges into queued I2C register-write messages
// and dispatches them to the I2C master with NACK retry.
module alarm_i2c_msg_queue
    import alarm_i2c_pkg::*;
#(
    parameter int         N_SENSORS = 4,
    parameter int         DEPTH     = 4,
    parameter logic [6:0] DEV_ADDR  = DEV_ADDR_DEFAULT,
    parameter int         MAX_RETRY = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_SENSORS-1:0] evt_in,
    input  logic                 armed,
    input  logic                 clr_status,
    output logic                 msg_valid,
    output logic [6:0]           msg_addr,
    output logic [7:0]           msg_reg,
    output logic [7:0]           msg_data,
    input  logic                 msg_ready,
    input  logic                 xfer_done,
    input  logic                 xfer_nack,
    output logic                 busy,
    output logic                 overflow,
    output logic                 nack_err,
    output logic [7:0]           drop_count
);

    localparam int IW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t                 state, state_next;
    logic [RW-1:0]          retry, retry_next;
    logic [N_SENSORS-1:0]   prev, pending, pending_next;
    logic [N_SENSORS-1:0]   rise, loss, push_mask;
    logic [IW-1:0]          push_idx;
    logic [7:0]             seq;
    logic [3:0]             n_lost;
    logic [8:0]             drop_sum;
    logic [7:0]             drop_base;
    logic                   push, pop, nack_set;
    logic                   fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    msg_t                   entry, head;

    sync_fifo #(
        .WIDTH ($bits(msg_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .pop   (pop),
        .din   (entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Edge detect, lowest-index pending selection and loss accounting.
    always_comb begin
        rise     = evt_in & ~prev & {N_SENSORS{armed}};
        push_idx = '0;
        for (int unsigned i = N_SENSORS; i > 0; i--) begin
            if (pending[i-1]) push_idx = IW'(i - 1);
        end
        push      = (pending != '0) && !fifo_full;
        push_mask = push ? (N_SENSORS'(1) << push_idx) : '0;
        entry.regnum = REG_SENSOR_BASE + 8'(push_idx);
        entry.data   = seq;
        // A rise on a sensor whose pending bit is leaving this very cycle
        // re-arms it instead of being counted as lost.
        loss         = rise & pending & ~push_mask;
        pending_next = armed ? ((pending & ~push_mask) | rise) : '0;
        n_lost = '0;
        for (int unsigned i = 0; i < N_SENSORS; i++) begin
            n_lost = n_lost + 4'(loss[i]);
        end
    end

    // Sensor history, pending flags and sequence number.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            prev    <= '0;
            pending <= '0;
            seq     <= '0;
        end else begin
            prev    <= evt_in;
            pending <= pending_next;
            if (push) seq <= seq + 8'd1;
        end
    end

    // Dispatch state register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            retry <= '0;
        end else begin
            state <= state_next;
            retry <= retry_next;
        end
    end

    // Dispatch next-state, handshake and pop decisions.
    always_comb begin
        state_next = state;
        retry_next = retry;
        pop        = 1'b0;
        nack_set   = 1'b0;
        msg_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_next = OFFER;
            end
            OFFER: begin
                msg_valid = 1'b1;
                if (msg_ready) state_next = WAIT;
            end
            WAIT: begin
                if (xfer_nack) begin
                    if (retry < RW'(MAX_RETRY)) begin
                        retry_next = retry + 1'b1;
                        state_next = OFFER;
                    end else begin
                        pop        = 1'b1;
                        nack_set   = 1'b1;
                        retry_next = '0;
                        state_next = IDLE;
                    end
                end else if (xfer_done) begin
                    pop        = 1'b1;
                    retry_next = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Saturating loss counter input; clear applies first so a same-cycle loss survives.
    always_comb begin
        drop_base = clr_status ? 8'd0 : drop_count;
        drop_sum  = {1'b0, drop_base} + 9'(n_lost);
    end

    // Sticky status; a set event in the same cycle as clr_status wins.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            overflow   <= 1'b0;
            nack_err   <= 1'b0;
            drop_count <= '0;
        end else begin
            overflow   <= (loss != '0) | (overflow & ~clr_status);
            nack_err   <= nack_set | (nack_err & ~clr_status);
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    assign msg_addr = msg_valid ? DEV_ADDR    : '0;
    assign msg_reg  = msg_valid ? head.regnum : '0;
    assign msg_data = msg_valid ? head.data   : '0;
    assign busy     = (fifo_count != '0) || (state != IDLE);

endmodule

// File: tb/tb_alarm_i2c_msg_queue.sv
// Directed self-checking bench for alarm_i2c_msg_queue.
module tb_alarm_i2c_msg_queue;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] evt_in = '0;
    logic       armed = 1'b0;
    logic       clr_status = 1'b0;
    logic       msg_ready = 1'b0;
    logic       xfer_done = 1'b0;
    logic       xfer_nack = 1'b0;
    logic       msg_valid;
    logic [6:0] msg_addr;
    logic [7:0] msg_reg;
    logic [7:0] msg_data;
    logic       busy;
    logic       overflow;
    logic       nack_err;
    logic [7:0] drop_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    alarm_i2c_msg_queue #(
        .N_SENSORS (4),
        .DEPTH     (4),
        .DEV_ADDR  (7'h20),
        .MAX_RETRY (3)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .evt_in     (evt_in),
        .armed      (armed),
        .clr_status (clr_status),
        .msg_valid  (msg_valid),
        .msg_addr   (msg_addr),
        .msg_reg    (msg_reg),
        .msg_data   (msg_data),
        .msg_ready  (msg_ready),
        .xfer_done  (xfer_done),
        .xfer_nack  (xfer_nack),
        .busy       (busy),
        .overflow   (overflow),
        .nack_err   (nack_err),
        .drop_count (drop_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        evt_in = '0; msg_ready = 1'b0; xfer_done = 1'b0; xfer_nack = 1'b0; clr_status = 1'b0;
        step(); step();
        RST = 1'b1;
        step();
    endtask

    task automatic pulse(input int idx);
        evt_in[idx] = 1'b1;
        step();
        evt_in[idx] = 1'b0;
        step();
    endtask

    task automatic wait_valid(input string tag);
        int unsigned n = 0;
        while (!msg_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 32'(msg_valid), 32'd1);
    endtask

    task automatic handshake_done();
        msg_ready = 1'b1; step(); msg_ready = 1'b0;
        xfer_done = 1'b1; step(); xfer_done = 1'b0;
    endtask

    task automatic handshake_nack();
        msg_ready = 1'b1; step(); msg_ready = 1'b0;
        xfer_nack = 1'b1; step(); xfer_nack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        step();
        // Reset state
        do_reset();
        check("rst_valid", 32'(msg_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_nack", 32'(nack_err), 0);
        check("rst_drop", 32'(drop_count), 0);
        check("rst_addr", 32'(msg_addr), 0);

        // Single event: exact two-edge latency to msg_valid
        armed = 1'b1;
        step();
        evt_in[2] = 1'b1;
        step();                       // edge k: rise sampled
        evt_in[2] = 1'b0;
        check("lat_k_valid", 32'(msg_valid), 0);
        step();                       // edge k+1: push
        check("lat_k1_valid", 32'(msg_valid), 0);
        check("lat_k1_busy", 32'(busy), 1);
        step();                       // edge k+2: offer
        check("lat_k2_valid", 32'(msg_valid), 1);
        check("single_addr", 32'(msg_addr), 32'h20);
        check("single_reg", 32'(msg_reg), 32'h12);
        check("single_data", 32'(msg_data), 32'h00);
        msg_ready = 1'b1; step(); msg_ready = 1'b0;
        check("wait_valid_low", 32'(msg_valid), 0);
        xfer_done = 1'b1; step(); xfer_done = 1'b0;
        check("done_busy", 32'(busy), 0);
        pulse(2);
        wait_valid("second");
        check("second_data", 32'(msg_data), 32'h01);
        handshake_done();

        // Simultaneous events drain lowest index first
        do_reset();
        armed = 1'b1;
        evt_in = 4'b1011; step(); evt_in = '0;
        wait_valid("sim0");
        check("sim0_reg", 32'(msg_reg), 32'h10);
        check("sim0_data", 32'(msg_data), 32'h00);
        handshake_done();
        wait_valid("sim1");
        check("sim1_reg", 32'(msg_reg), 32'h11);
        check("sim1_data", 32'(msg_data), 32'h01);
        handshake_done();
        wait_valid("sim2");
        check("sim2_reg", 32'(msg_reg), 32'h13);
        check("sim2_data", 32'(msg_data), 32'h02);
        handshake_done();
        check("sim_busy", 32'(busy), 0);

        // NACK retry exhaustion, then FIFO advances
        do_reset();
        armed = 1'b1;
        pulse(1);
        pulse(2);
        for (int a = 0; a < 4; a++) begin
            wait_valid("nack_try");
            check("nack_try_reg", 32'(msg_reg), 32'h11);
            check("nack_try_data", 32'(msg_data), 32'h00);
            check("nack_err_early", 32'(nack_err), 0);
            handshake_nack();
        end
        check("nack_err_set", 32'(nack_err), 1);
        wait_valid("nack_next");
        check("nack_next_reg", 32'(msg_reg), 32'h12);
        check("nack_next_data", 32'(msg_data), 32'h01);
        clr_status = 1'b1; step(); clr_status = 1'b0;
        check("nack_err_clr", 32'(nack_err), 0);
        // done and nack together: nack wins, entry re-offered
        msg_ready = 1'b1; step(); msg_ready = 1'b0;
        xfer_done = 1'b1; xfer_nack = 1'b1; step(); xfer_done = 1'b0; xfer_nack = 1'b0;
        check("both_reoffer", 32'(msg_valid), 1);
        check("both_reg", 32'(msg_reg), 32'h12);
        handshake_done();
        check("retry_ok_nack_err", 32'(nack_err), 0);
        check("retry_ok_busy", 32'(busy), 0);

        // Overflow with master stalled
        do_reset();
        armed = 1'b1;
        msg_ready = 1'b0;
        for (int r = 0; r < 6; r++) pulse(0);
        step();
        check("ovf_drop", 32'(drop_count), 1);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_head_data", 32'(msg_data), 32'h00);
        check("ovf_busy", 32'(busy), 1);
        clr_status = 1'b1; step(); clr_status = 1'b0;
        check("ovf_clr_drop", 32'(drop_count), 0);
        check("ovf_clr_flag", 32'(overflow), 0);

        // Disarmed: nothing captured
        do_reset();
        armed = 1'b0;
        pulse(0);
        pulse(3);
        step(); step();
        check("disarm_busy", 32'(busy), 0);
        check("disarm_valid", 32'(msg_valid), 0);

        // Reset during WAIT with three entries queued
        armed = 1'b1;
        pulse(0); pulse(1); pulse(2);
        wait_valid("rstw");
        msg_ready = 1'b1; step(); msg_ready = 1'b0;
        check("rstw_busy_pre", 32'(busy), 1);
        RST = 1'b0; step();
        check("rstw_valid", 32'(msg_valid), 0);
        check("rstw_busy", 32'(busy), 0);
        check("rstw_addr", 32'(msg_addr), 0);
        check("rstw_reg", 32'(msg_reg), 0);
        check("rstw_data", 32'(msg_data), 0);
        RST = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (msg_valid || busy) seen = 1'b1;
        end
        check("rstw_no_reoffer", 32'(seen), 0);

        // Sequence number wraps after 256 messages
        do_reset();
        armed = 1'b1;
        for (int m = 0; m < 256; m++) begin
            pulse(0);
            wait_valid("wrap");
            check("wrap_data", 32'(msg_data), 32'(m & 8'hFF));
            handshake_done();
        end
        pulse(0);
        wait_valid("wrap257");
        check("wrap257_data", 32'(msg_data), 32'h00);
        handshake_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_i2c_msg_queue.md
Name: alarm_i2c_msg_queue

Overview:
- Upstream feeder for the I2C master automaton: turns alarm sensor events into queued I2C register-write messages.
- Edge-detects sensor inputs while the system is armed, buffers messages in a small FIFO, and offers them one at a time over a valid/ready handshake.
- Tracks completion or NACK from the master, retries NACKed writes, and keeps sticky status for overflow and give-up.

Parameters:
- N_SENSORS, 4, number of sensor inputs (1..8).
- DEPTH, 4, FIFO entries (power of 2, >=2).
- DEV_ADDR, 7'h20, 7-bit I2C address of the alarm display/log device.
- MAX_RETRY, 3, retries after the first NACK before the message is dropped.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-low.
- evt_in  in  N_SENSORS  sensor levels, already synchronised; a rising edge = event.
- armed  in  1  events accepted only while 1.
- clr_status  in  1  one-cycle pulse; clears overflow, nack_err and drop_count.
- msg_valid  out  1  message offered to the I2C master.
- msg_addr  out  7  always DEV_ADDR.
- msg_reg  out  8  8'h10 + sensor index.
- msg_data  out  8  sequence number of the message.
- msg_ready  in  1  master accepts the message.
- xfer_done  in  1  one-cycle pulse: write ACKed end to end.
- xfer_nack  in  1  one-cycle pulse: write NACKed.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- overflow  out  1  sticky; set when an event is lost.
- nack_err  out  1  sticky; set when a message exhausts its retries.
- drop_count  out  8  lost events, saturating at 255.

Behaviour:
Reset:
- All outputs 0. Edge-detect history = 0, pending = 0, FIFO empty, seq = 0, FSM = IDLE.
- Reset mid-transfer discards everything; no message is re-offered.

Event capture:
- rise[i] = evt_in[i] & ~prev[i] & armed. prev updates every cycle.
- A rise sets pending[i] at the next edge.
- A rise while pending[i] is already 1 counts as a loss: drop_count += 1 (saturating) and overflow is set.
- armed = 0 clears pending but does not touch the FIFO or an in-flight message.

Enqueue:
- Each cycle, if pending != 0 and the FIFO is not full, push the lowest set index i. Entry = {reg = 8'h10 + i, data = seq}.
- On push, clear pending[i] and set seq = seq + 1 (8-bit wrap, 255 -> 0).
- FIFO full: no push; pending holds.
- Push and pop in the same cycle are both allowed; count is unchanged.

Dispatch FSM:
- IDLE: go to OFFER if the FIFO is non-empty (registered count).
- OFFER: msg_valid = 1, driven from the FIFO head. Fields stay stable until msg_valid & msg_ready, then go to WAIT.
- WAIT: msg_valid = 0.
  - xfer_done: pop, clear the retry counter, go to IDLE.
  - xfer_nack with retry < MAX_RETRY: retry + 1, go back to OFFER with the same entry.
  - xfer_nack with retry = MAX_RETRY: pop, set nack_err, clear retry, go to IDLE.
  - xfer_done and xfer_nack together: nack wins.
- xfer_done/xfer_nack are ignored outside WAIT.

Latency and status:
- Rise sampled at edge k -> pending at k -> push at k+1 -> msg_valid high after edge k+2 (FSM idle, FIFO empty).
- clr_status takes effect at the next edge. If it coincides with a new set event, the set wins.

Decomposition:
- Shared package alarm_i2c_pkg holds:
  - message struct {reg, data}
  - REG_SENSOR_BASE = 8'h10
  - FSM state enum IDLE/OFFER/WAIT
  - DEV_ADDR default
- Sub-module sync_fifo: parameterised WIDTH/DEPTH, push/pop/full/empty/count, first-word-fall-through head.

Test Plan:
- Armed, single event: rise on evt_in[2] at cycle 10 -> msg_valid at cycle 12 with addr 7'h20, reg 8'h12, data 8'h00. msg_ready then xfer_done -> busy drops; next event carries data 8'h01.
- Simultaneous events: evt_in 4'b1011 rises in one cycle -> messages offered in order reg 8'h10, 8'h11, 8'h13 with data 0, 1, 2.
- NACK retry: MAX_RETRY = 3 and xfer_nack every attempt -> the same entry is offered 4 times, then popped; nack_err = 1, FIFO advances. A done on the 2nd attempt -> nack_err stays 0.
- Overflow: msg_ready held 0, DEPTH = 4, 6 distinct rises on sensor 0 -> 4 queued, 1 pending, 1 lost. drop_count = 1, overflow = 1; clr_status clears both to 0.
- Disarm and reset: rises with armed = 0 -> nothing queued. RST low during WAIT with 3 entries queued -> all outputs 0 next cycle, no re-offer after release.
- Sequence wrap: 256 completed messages -> message 257 carries data 8'h00.
